audio_serial_bridge: RTL
========================

// Module: audio_serial_bridge
// PURPOSE
//  Parametrised ADC->DSP->DAC serial-audio bridge, replacing the hard-wired pin loopback.
//  Oversamples ADC bck/lrck/adata in the clk domain and deserialises each slot to a parallel
//  sample with channel tag. Accepts processed samples back and reserialises them to DAC pins.
//  Supports I2S / left-justified formats, 2-ch or TDM framing, and an internal bypass loop.
// PARAMETERS
//  SAMPLE_W   24  bits per audio sample (MSB first), <= SLOT_W
//  SLOT_W     32  bck periods per channel slot
//  NUM_CH     2   channels per frame (2=stereo, 4/8=TDM)
//  FS_EDGE    0   lrck edge marking frame start: 0=falling, 1=rising
//  LRCK_INV   1   invert lrck toward DAC (DAC/ADC lrck polarity opposite)
// PORTS
//  clk          in   1          system clock, >= 8x bck
//  rst_n        in   1          async active-low reset
//  i_adc_bck    in   1          ADC bit clock (async)
//  i_adc_lrck   in   1          ADC frame/word clock (async)
//  i_adc_adata  in   1          ADC serial data (async)
//  i_fmt        in   1          0=I2S (MSB one bck after slot start), 1=left-justified
//  i_bypass     in   1          1=DAC plays rx samples internally, ignores i_tx_*
//  o_rx_sample  out  SAMPLE_W   received sample
//  o_rx_chan    out  clog2(NUM_CH)  channel of o_rx_sample
//  o_rx_valid   out  1          one-clk strobe, no backpressure
//  i_tx_sample  in   SAMPLE_W   processed sample to play
//  i_tx_chan    in   clog2(NUM_CH)  channel of i_tx_sample
//  i_tx_valid   in   1          writes holding register i_tx_chan
//  o_dac_bck    out  1          regenerated bit clock
//  o_dac_lrck   out  1          regenerated lrck (inverted if LRCK_INV)
//  o_dac_adata  out  1          DAC serial data
//  o_locked     out  1          high after first frame-start edge
//  o_underrun   out  1          one-clk pulse: slot loaded with no fresh tx sample
//  o_frame_err  out  1          one-clk pulse: frame edge at wrong bit count
// BEHAVIOUR
//  - Reset: all outputs 0, holding regs 0, o_locked 0; applies immediately, mid-frame ok.
//  - bck, lrck, adata each pass 2-FF sync + 1 edge reg; detected edges lag pins by 3 clk.
//  - o_dac_bck = delayed bck; o_dac_lrck = delayed lrck ^ LRCK_INV; both 3 clk after pins.
//  - Bit counter (0..NUM_CH*SLOT_W-1) advances on detected bck rise; cleared on FS_EDGE.
//  - Unlocked: no rx_valid, DAC data 0, until first frame edge; then o_locked=1.
//  - Frame edge when counter != NUM_CH*SLOT_W-1 (locked) -> o_frame_err, resync to 0.
//  - slot = count/SLOT_W; bit = count%SLOT_W; off = i_fmt ? 0 : 1.
//  - Rx: adata shifted on bck rise for off <= bit < off+SAMPLE_W; o_rx_valid 1 clk after
//    rise of bit off+SAMPLE_W-1, with o_rx_chan=slot. Other bits ignored.
//  - Tx: i_tx_valid writes hold[i_tx_chan], sets fresh[i_tx_chan]. Same-clk write and load
//    of same channel: new data loaded, fresh ends cleared.
//  - On bck fall of bit off-1 (I2S) / slot start (LJ) shifter loads hold[slot] (bypass:
//    last rx sample of slot); if !bypass && !fresh: load 0, o_underrun. fresh cleared.
//  - o_dac_adata updates on detected bck fall: MSB first, SAMPLE_W bits, then 0 to slot end.
//  - i_fmt/i_bypass sampled at frame start only; mid-frame changes take effect next frame.
// STRUCTURE
//  - audio_pkg: fmt enum (FMT_I2S, FMT_LJ), SYNC_STAGES=2, clog2 helper.
//  - Sub-module serial_edge_sync: 2-FF sync + rise/fall strobes; one each for bck, lrck.
//  - Top: bit counter, rx shifter, hold reg array + fresh bits, tx shifter.
// TESTING
//  - I2S 2ch, L=0xABCDEF R=0x123456 -> rx_valid chan0 0xABCDEF then chan1 0x123456.
//  - Same, i_fmt=1 with LJ stimulus -> identical samples; I2S bench under LJ -> shifted 1 bit.
//  - bypass=1, rx 0x800001 -> DAC bitstream 0x800001 one frame later, lrck inverted.
//  - tx writes only chan0 -> chan1 slot plays 0, o_underrun once per frame.
//  - NUM_CH=4, SLOT_W=32, FS_EDGE=1 TDM -> chans 0..3 tagged in order.
//  - Short frame (60 bck) -> o_frame_err pulse, next frame decodes. rst_n low mid-slot
//    -> outputs 0, o_locked 0 until next frame edge.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the serial-audio bridge.
// Provides the format enum, synchroniser depth and a clog2 helper.
package audio_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  localparam int SYNC_STAGES = 2;

  // Minimum result is 1 so one-channel / one-bit fields stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_edge_sync.sv
// serial_edge_sync: 2-FF synchroniser plus edge register for one async pin.
// Ports: clk, rst_n, i_pin in; o_level (delayed pin), o_rise, o_fall strobes out.
module serial_edge_sync
  import audio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic synced;

  // Strobes are registered alongside the level so both lag the pin equally.
  always_comb begin
    synced = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
    lvl_d  = synced;
    rise_d = synced & ~lvl_q;
    fall_d = ~synced & lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_level = lvl_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/audio_serial_bridge.sv
// audio_serial_bridge: ADC serial in -> parallel rx samples; tx samples -> DAC serial out.
// Ports: ADC bck/lrck/adata in, rx sample/chan/valid out, tx sample/chan/valid in, DAC pins, status.
module audio_serial_bridge
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W = 24,
  parameter  int SLOT_W   = 32,
  parameter  int NUM_CH   = 2,
  parameter  int FS_EDGE  = 0,
  parameter  int LRCK_INV = 1,
  localparam int CH_W     = clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_adc_bck,
  input  logic                i_adc_lrck,
  input  logic                i_adc_adata,
  input  logic                i_fmt,
  input  logic                i_bypass,
  output logic [SAMPLE_W-1:0] o_rx_sample,
  output logic [CH_W-1:0]     o_rx_chan,
  output logic                o_rx_valid,
  input  logic [SAMPLE_W-1:0] i_tx_sample,
  input  logic [CH_W-1:0]     i_tx_chan,
  input  logic                i_tx_valid,
  output logic                o_dac_bck,
  output logic                o_dac_lrck,
  output logic                o_dac_adata,
  output logic                o_locked,
  output logic                o_underrun,
  output logic                o_frame_err
);

  localparam int   FRAME    = NUM_CH * SLOT_W;
  localparam int   CNT_W    = clog2(FRAME);
  localparam logic LRCK_POL = (LRCK_INV != 0);

  logic bck_lvl, bck_rise, bck_fall;
  logic lrck_lvl, lrck_rise, lrck_fall;
  logic fs;

  serial_edge_sync u_bck (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (i_adc_bck),
    .o_level (bck_lvl),
    .o_rise  (bck_rise),
    .o_fall  (bck_fall)
  );

  serial_edge_sync u_lrck (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (i_adc_lrck),
    .o_level (lrck_lvl),
    .o_rise  (lrck_rise),
    .o_fall  (lrck_fall)
  );

  assign fs = (FS_EDGE != 0) ? lrck_rise : lrck_fall;

  // Data gets the same depth as bck so it is sampled at the true bck rise.
  logic [SYNC_STAGES:0] adata_q, adata_d;
  logic                 adata;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                locked_q, locked_d;
  fmt_e                fmt_q, fmt_d;
  logic                byp_q, byp_d;
  logic [SAMPLE_W-1:0] rx_sh_q, rx_sh_d;
  logic [SAMPLE_W-1:0] rx_sample_q, rx_sample_d;
  logic [CH_W-1:0]     rx_chan_q, rx_chan_d;
  logic                rx_valid_q, rx_valid_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] last_q, last_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0]   fresh_q, fresh_d;
  logic [SAMPLE_W-1:0] tx_sh_q, tx_sh_d;
  logic                dac_q, dac_d;
  logic                underrun_q, underrun_d;
  logic                frame_err_q, frame_err_d;

  fmt_e                fmt_eff;
  logic                byp_eff;
  int                  off;
  int                  pos;
  int                  pos_slot;
  int                  pos_bit;
  logic [CH_W-1:0]     slot_idx;
  logic [SAMPLE_W-1:0] rx_word;
  logic [SAMPLE_W-1:0] tx_word;

  always_comb begin
    adata_d     = {adata_q[SYNC_STAGES-1:0], i_adc_adata};
    adata       = adata_q[SYNC_STAGES];
    cnt_d       = cnt_q;
    first_d     = first_q;
    locked_d    = locked_q;
    fmt_d       = fmt_q;
    byp_d       = byp_q;
    rx_sh_d     = rx_sh_q;
    rx_sample_d = rx_sample_q;
    rx_chan_d   = rx_chan_q;
    rx_valid_d  = 1'b0;
    last_d      = last_q;
    hold_d      = hold_q;
    fresh_d     = fresh_q;
    tx_sh_d     = tx_sh_q;
    dac_d       = dac_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    // Mode is latched at frame start; on the frame-start cycle use the pins.
    fmt_eff = fs ? fmt_e'(i_fmt) : fmt_q;
    byp_eff = fs ? i_bypass : byp_q;
    off     = (fmt_eff == FMT_I2S) ? 1 : 0;

    // pos = index of the bit whose bck rise comes next.
    if (first_q || fs || int'(cnt_q) == FRAME - 1) pos = 0;
    else pos = int'(cnt_q) + 1;
    pos_slot = pos / SLOT_W;
    pos_bit  = pos % SLOT_W;
    slot_idx = CH_W'(pos_slot);
    rx_word  = {rx_sh_q[SAMPLE_W-2:0], adata};
    tx_word  = tx_sh_q;

    if (i_tx_valid && int'(i_tx_chan) < NUM_CH) begin
      hold_d[i_tx_chan]  = i_tx_sample;
      fresh_d[i_tx_chan] = 1'b1;
    end

    if (bck_rise && locked_q) begin
      cnt_d   = CNT_W'(pos);
      first_d = 1'b0;
      if (pos_bit >= off && pos_bit < off + SAMPLE_W) begin
        rx_sh_d = rx_word;
        if (pos_bit == off + SAMPLE_W - 1) begin
          rx_valid_d       = 1'b1;
          rx_sample_d      = rx_word;
          rx_chan_d        = slot_idx;
          last_d[slot_idx] = rx_word;
        end
      end
    end

    // The fall ahead of a slot's MSB loads the shifter; hold_d/fresh_d
    // already include a same-cycle tx write.
    if (bck_fall && (locked_q || fs)) begin
      if (pos_bit == off) begin
        if (byp_eff) begin
          tx_word = last_q[slot_idx];
        end else if (fresh_d[slot_idx]) begin
          tx_word = hold_d[slot_idx];
        end else begin
          tx_word    = '0;
          underrun_d = 1'b1;
        end
        fresh_d[slot_idx] = 1'b0;
      end
      dac_d   = tx_word[SAMPLE_W-1];
      tx_sh_d = tx_word << 1;
    end

    if (fs) begin
      if (locked_q && int'(cnt_q) != FRAME - 1) frame_err_d = 1'b1;
      locked_d = 1'b1;
      cnt_d    = '0;
      first_d  = 1'b1;
      fmt_d    = fmt_e'(i_fmt);
      byp_d    = i_bypass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adata_q     <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      locked_q    <= 1'b0;
      fmt_q       <= FMT_I2S;
      byp_q       <= 1'b0;
      rx_sh_q     <= '0;
      rx_sample_q <= '0;
      rx_chan_q   <= '0;
      rx_valid_q  <= 1'b0;
      last_q      <= '0;
      hold_q      <= '0;
      fresh_q     <= '0;
      tx_sh_q     <= '0;
      dac_q       <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      adata_q     <= adata_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      locked_q    <= locked_d;
      fmt_q       <= fmt_d;
      byp_q       <= byp_d;
      rx_sh_q     <= rx_sh_d;
      rx_sample_q <= rx_sample_d;
      rx_chan_q   <= rx_chan_d;
      rx_valid_q  <= rx_valid_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      fresh_q     <= fresh_d;
      tx_sh_q     <= tx_sh_d;
      dac_q       <= dac_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_rx_sample = rx_sample_q;
  assign o_rx_chan   = rx_chan_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_dac_bck   = bck_lvl;
  // Held low until framing is known so reset leaves every output at 0.
  assign o_dac_lrck  = locked_q & (lrck_lvl ^ LRCK_POL);
  assign o_dac_adata = dac_q;
  assign o_locked    = locked_q;
  assign o_underrun  = underrun_q;
  assign o_frame_err = frame_err_q;

endmodule
